// File: rtl/mult_share_pkg.sv
// Shared sizing for the multiplier-sharing arbiter: default widths and operand/product types.
// No logic: constants and typedefs only.
// Not applicable: no handshakes live here.
package mult_share_pkg;

    localparam int W_DEF    = 4;
    localparam int NREQ_DEF = 4;
    localparam int ID_W     = $clog2(NREQ_DEF);

    typedef logic [W_DEF-1:0]   operand_t;
    typedef logic [2*W_DEF-1:0] product_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot request arbiter; round-robin when MULT_SHARE_RR_EN is defined, else fixed lowest-index priority.
// Latency: grant is combinational from req_i and the pointer.
// Backpressure: pointer moves only on adv_i, so a grant that is not taken does not rotate priority.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            adv_i,
    output logic [NREQ-1:0] gnt_o
);

    localparam int PW = $clog2(NREQ);

`ifdef MULT_SHARE_RR_EN
    logic [PW-1:0] ptr_q, ptr_d;

    // Search starts one past the last winner and wraps modulo NREQ.
    always_comb begin : rr_pick
        logic found;
        int   idx;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (adv_i && gnt_o[k]) begin
                ptr_d = PW'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, adv_i};

    // Isolate the lowest set bit.
    assign gnt_o = req_i & (~req_i + NREQ'(1));
`endif

endmodule

// File: rtl/mult_share_arb.sv
// Shares one external combinational multiplier among NREQ requesters; round-robin via MULT_SHARE_RR_EN.
// Latency: 2 cycles from request handshake to rsp_valid; 1 request per cycle sustained.
// Backpressure: rsp_ready low stalls S2, then S1, then drops every req_ready.
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_x,
    input  logic [NREQ*W-1:0]        req_y,
    output logic [W-1:0]             mul_x,
    output logic [W-1:0]             mul_y,
    input  logic [2*W-1:0]           mul_p,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [2*W-1:0]           rsp_p
);

    localparam int IW = $clog2(NREQ);

    logic            s1_v_q, s1_v_d;
    logic [W-1:0]    s1_x_q, s1_x_d;
    logic [W-1:0]    s1_y_q, s1_y_d;
    logic [IW-1:0]   s1_id_q, s1_id_d;
    logic            s2_v_q, s2_v_d;
    logic [2*W-1:0]  s2_p_q, s2_p_d;
    logic [IW-1:0]   s2_id_q, s2_id_d;

    logic            s1_free, s2_free, accept;
    logic [NREQ-1:0] gnt;
    logic [W-1:0]    sel_x, sel_y;
    logic [IW-1:0]   sel_id;

    assign s2_free = !s2_v_q || rsp_ready;
    assign s1_free = !s1_v_q || s2_free;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req_valid),
        .adv_i (accept),
        .gnt_o (gnt)
    );

    // Grant only targets valid requesters, so req_ready alone marks a handshake.
    assign req_ready = gnt & {NREQ{s1_free && rst_n}};
    assign accept    = |req_ready;

    always_comb begin
        sel_x  = '0;
        sel_y  = '0;
        sel_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_x  = req_x[i*W +: W];
                sel_y  = req_y[i*W +: W];
                sel_id = IW'(i);
            end
        end
    end

    always_comb begin
        s1_v_d  = s1_v_q && !s2_free;
        s1_x_d  = s1_x_q;
        s1_y_d  = s1_y_q;
        s1_id_d = s1_id_q;
        if (accept) begin
            s1_v_d  = 1'b1;
            s1_x_d  = sel_x;
            s1_y_d  = sel_y;
            s1_id_d = sel_id;
        end

        s2_v_d  = s2_v_q && !rsp_ready;
        s2_p_d  = s2_p_q;
        s2_id_d = s2_id_q;
        if (s1_v_q && s2_free) begin
            s2_v_d  = 1'b1;
            s2_p_d  = mul_p;
            s2_id_d = s1_id_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q  <= 1'b0;
            s1_x_q  <= '0;
            s1_y_q  <= '0;
            s1_id_q <= '0;
            s2_v_q  <= 1'b0;
            s2_p_q  <= '0;
            s2_id_q <= '0;
        end else begin
            s1_v_q  <= s1_v_d;
            s1_x_q  <= s1_x_d;
            s1_y_q  <= s1_y_d;
            s1_id_q <= s1_id_d;
            s2_v_q  <= s2_v_d;
            s2_p_q  <= s2_p_d;
            s2_id_q <= s2_id_d;
        end
    end

    assign mul_x     = s1_x_q;
    assign mul_y     = s1_y_q;
    assign rsp_valid = s2_v_q;
    assign rsp_p     = s2_p_q;
    assign rsp_id    = s2_id_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Randomised scoreboard bench for mult_share_arb against a capacity-2, in-order reference model.
module tb_mult_share_arb;
    import mult_share_pkg::*;

    localparam int NREQ = NREQ_DEF;
    localparam int W    = W_DEF;
    localparam int IW   = ID_W;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid, req_ready;
    logic [NREQ*W-1:0]   req_x, req_y;
    logic [W-1:0]        mul_x, mul_y;
    product_t            mul_p;
    logic                rsp_valid, rsp_ready;
    logic [IW-1:0]       rsp_id;
    logic [2*W-1:0]      rsp_p;

    always #5 clk = ~clk;

    // Environment's multiplier: a plain combinational product.
    assign mul_p = product_t'(mul_x) * product_t'(mul_y);

    mult_share_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p)
    );

    typedef struct {
        int id;
        int p;
        int acc;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              last_id = NREQ - 1;
    int              peak = 0;
    logic [NREQ-1:0] last_hs = '0;
    bit              prev_stall = 1'b0;
    bit              mon_en = 1'b0;
    logic [IW-1:0]   prev_id = '0;
    logic [2*W-1:0]  prev_p = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Winner by the arbitration rule: scan from last winner + 1 (round-robin) or from index 0.
    function automatic int model_pick(input logic [NREQ-1:0] v, input int last);
`ifdef MULT_SHARE_RR_EN
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            if (v[k]) return k;
        end
`endif
        return -1;
    endfunction

    // Monitor: the pipeline holds at most two requests, answers in order, 2 cycles after accept.
    always @(negedge clk) begin : mon
        logic [NREQ-1:0] exp_rdy;
        int              pick;
        bit              exp_v;
        exp_t            h;
        exp_t            e;
        if (rst_n && mon_en) begin
            exp_rdy = '0;
            pick    = model_pick(req_valid, last_id);
            if ((sb.size() < 2 || rsp_ready) && pick >= 0) exp_rdy[pick] = 1'b1;
            chk("req_ready", int'(req_ready), int'(exp_rdy));

            exp_v = (sb.size() >= 2) || (sb.size() == 1 && sb[0].acc < cyc - 1);
            chk("rsp_valid", int'(rsp_valid), int'(exp_v));

            if (prev_stall) begin
                chk("hold_id", int'(rsp_id), int'(prev_id));
                chk("hold_p", int'(rsp_p), int'(prev_p));
            end

            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected_depth", 0, 1);
                end else begin
                    h = sb.pop_front();
                    chk("rsp_id", int'(rsp_id), h.id);
                    chk("rsp_p", int'(rsp_p), h.p);
                end
            end

            prev_stall = rsp_valid && !rsp_ready;
            prev_id    = rsp_id;
            prev_p     = rsp_p;

            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id  = i;
                    e.p   = int'(req_x[i*W +: W]) * int'(req_y[i*W +: W]);
                    e.acc = cyc;
                    sb.push_back(e);
                    last_id = i;
                end
            end
            last_hs = req_valid & req_ready;
            if (sb.size() > peak) peak = sb.size();
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requesters hold operands while valid and unaccepted; may drop valid, or start fresh.
    task automatic rand_cycle(input logic [NREQ-1:0] mask, input int drop_pct, input int vld_pct);
        for (int i = 0; i < NREQ; i++) begin
            if (mask[i]) begin
                if (req_valid[i] && !last_hs[i]) begin
                    if ($urandom_range(99) < drop_pct) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i]      = ($urandom_range(99) < vld_pct);
                    req_x[i*W +: W]   = W'($urandom);
                    req_y[i*W +: W]   = W'($urandom);
                end
            end
        end
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
        chk("drain_empty", sb.size(), 0);
        repeat (2) tick();
    endtask

    initial begin
        int idx;
        int bound;
        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b0;

        // Reset values, with requesters already asserting valid.
        #2;
        req_valid = '1;
        req_x     = '1;
        req_y     = '1;
        #1;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_p", int'(rsp_p), 0);
        chk("rst_mul_x", int'(mul_x), 0);
        chk("rst_mul_y", int'(mul_y), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n     = 1'b1;
        req_valid = '0;
        mon_en    = 1'b1;

        // Contention: everyone always valid.
        rsp_ready = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            tick();
            if (c > 0) begin
`ifdef MULT_SHARE_RR_EN
                chk("contention_grant", int'(last_hs), 1 << ((c - 1) % NREQ));
`else
                chk("contention_grant", int'(last_hs), 1);
`endif
            end
            rand_cycle('1, 0, 100);
        end
        drain();

        // Single request from requester 2.
        tick();
        req_valid          = 4'b0100;
        req_x[2*W +: W]    = W'(3);
        req_y[2*W +: W]    = W'(5);
        rsp_ready          = 1'b1;
        @(negedge clk);
        chk("single_req_ready", int'(req_ready), 4);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("single_c1_valid", int'(rsp_valid), 0);
        @(negedge clk);
        chk("single_c2_valid", int'(rsp_valid), 1);
        chk("single_c2_id", int'(rsp_id), 2);
        chk("single_c2_p", int'(rsp_p), 15);
        @(negedge clk);
        chk("single_c3_valid", int'(rsp_valid), 0);
        drain();

        // Backpressure: 15*15 stream from requester 1, consumer stalls cycles 3..5.
        peak = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            req_valid[1]    = 1'b1;
            req_x[1*W +: W] = W'(15);
            req_y[1*W +: W] = W'(15);
            rsp_ready       = !(c >= 3 && c <= 5);
        end
        drain();
        chk("bp_peak_inflight", peak, 2);

        // Fill both stages, then release the consumer for exactly one cycle.
        rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            rand_cycle('1, 0, 100);
        end
        tick();
        rsp_ready = 1'b1;
        rand_cycle('1, 0, 100);
        @(negedge clk);
        chk("fp_accept_any", int'(|req_ready), 1);
        chk("fp_rsp_valid", int'(rsp_valid), 1);
        tick();
        rsp_ready = 1'b0;
        rand_cycle('1, 0, 100);
        @(negedge clk);
        chk("fp_full_ready", int'(req_ready), 0);
        chk("fp_still_valid", int'(rsp_valid), 1);

        // Reset with both stages full.
        tick();
        #1;
        rst_n     = 1'b0;
        req_valid = '1;
        #1;
        chk("midrst_rsp_valid", int'(rsp_valid), 0);
        chk("midrst_req_ready", int'(req_ready), 0);
        chk("midrst_rsp_p", int'(rsp_p), 0);
        sb.delete();
        last_id    = NREQ - 1;
        last_hs    = '0;
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_first_grant", int'(req_ready), 1);
        drain();

        // Every operand pair through requester 3 with a random consumer.
        idx   = 0;
        bound = 0;
        while (idx < 256 && bound < 4000) begin
            tick();
            if (last_hs[3]) idx++;
            bound++;
            rsp_ready = 1'($urandom_range(1));
            if (idx < 256) begin
                req_valid[3]    = ($urandom_range(3) != 0);
                req_x[3*W +: W] = W'(idx / 16);
                req_y[3*W +: W] = W'(idx % 16);
            end else begin
                req_valid[3] = 1'b0;
            end
        end
        chk("exhaustive_count", idx, 256);
        drain();

        // Mixed random traffic from all requesters.
        for (int c = 0; c < 300; c++) begin
            tick();
            rsp_ready = ($urandom_range(99) < 70);
            rand_cycle('1, 10, 60);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
